ctrl_packet_receiver: RTL and testbench

Switch-side receiver for the control port byte protocol. Accepts a packet on `data_in` qualified by `sw_enable_in`: DA, SA, LENGTH, then LENGTH payload bytes. The packet is stored in an internal buffer and then forwarded with a valid/ready handshake to the switch core. `read_out` is the flow-control indication back to the sender. It sits between the control port pins and the switch routing logic.

---
 rtl/ctrl_packet_receiver.sv | 178 +++++++++++++++++
 tb/tb_ctrl_packet_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_packet_receiver.sv
// ctrl_packet_receiver: control-port byte receiver (DA, SA, LENGTH, payload) that buffers a
// packet and forwards it to the switch core over a valid/ready handshake. Rev 1.0
`default_nettype none

module ctrl_packet_receiver #(
  parameter int MAX_LEN = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  data_in,
  input  logic        sw_enable_in,
  output logic        read_out,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [7:0]  out_da,
  output logic [15:0] drop_count,
  output logic [15:0] overrun_count
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SA      = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DISCARD = 3'd4,
    S_FWD     = 3'd5
  } state_t;

  state_t        state;
  logic [7:0]    buffer [MAX_LEN];
  logic [7:0]    da;
  logic [7:0]    sa;
  logic [7:0]    len;
  logic [7:0]    remaining;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [8:0]    fwd_cnt;
  logic [7:0]    next_byte;
  logic          next_is_last;
  logic          accept;
  logic          handshake;

  assign accept    = sw_enable_in & read_out;
  assign handshake = out_valid & out_ready;

  // fwd_cnt indexes the byte about to be presented; payload starts at index 3.
  assign rd_idx       = AW'(fwd_cnt - 9'd3);
  assign next_is_last = (fwd_cnt == ({1'b0, len} + 9'd2));

  always_comb begin
    next_byte = buffer[rd_idx];
    if (fwd_cnt == 9'd1) begin
      next_byte = sa;
    end else if (fwd_cnt == 9'd2) begin
      next_byte = len;
    end
  end

  // Payload storage carries no reset; stale contents are never read.
  always_ff @(posedge clock) begin
    if (state == S_PAYLOAD && accept) begin
      buffer[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      da            <= 8'd0;
      sa            <= 8'd0;
      len           <= 8'd0;
      remaining     <= 8'd0;
      wr_idx        <= '0;
      fwd_cnt       <= 9'd0;
      read_out      <= 1'b1;
      out_valid     <= 1'b0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_data      <= 8'd0;
      out_da        <= 8'd0;
      drop_count    <= 16'd0;
      overrun_count <= 16'd0;
    end else begin
      if (sw_enable_in && !read_out && overrun_count != 16'hFFFF) begin
        overrun_count <= overrun_count + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            da    <= data_in;
            state <= S_SA;
          end
        end

        S_SA: begin
          if (accept) begin
            sa    <= data_in;
            state <= S_LEN;
          end
        end

        S_LEN: begin
          if (accept) begin
            len       <= data_in;
            remaining <= data_in;
            wr_idx    <= '0;
            if (data_in == 8'd0) begin
              state <= S_IDLE;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if ({1'b0, data_in} > MAX_LEN_9) begin
              state <= S_DISCARD;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
            wr_idx    <= wr_idx + 1'b1;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state     <= S_FWD;
              read_out  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= da;
              out_sop   <= 1'b1;
              out_eop   <= 1'b0;
              out_da    <= da;
              fwd_cnt   <= 9'd1;
            end
          end
        end

        S_DISCARD: begin
          if (accept) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= S_IDLE;
            end
          end
        end

        S_FWD: begin
          if (handshake) begin
            if (out_eop) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
              read_out  <= 1'b1;
            end else begin
              out_data <= next_byte;
              out_sop  <= 1'b0;
              out_eop  <= next_is_last;
              fwd_cnt  <= fwd_cnt + 9'd1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_packet_receiver.sv
// Directed self-checking bench for ctrl_packet_receiver.
`default_nettype none

module tb_ctrl_packet_receiver;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  data_in;
  logic        sw_enable_in;
  logic        read_out;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  out_da;
  logic [15:0] drop_count;
  logic [15:0] overrun_count;

  always #5 clock = ~clock;

  ctrl_packet_receiver #(.MAX_LEN(64)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .sw_enable_in (sw_enable_in),
    .read_out     (read_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_da       (out_da),
    .drop_count   (drop_count),
    .overrun_count(overrun_count)
  );

  int         passed = 0;
  int         total  = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] exp_da = 8'h00;
  logic [7:0] held = 8'h00;
  bit         stall_prev = 1'b0;
  bit         tog_mode = 1'b0;
  bit         tog = 1'b1;
  int         ro_low = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), observe outputs, advance.
  task automatic step(input logic en, input logic [7:0] d, input logic rdy);
    sw_enable_in = en;
    data_in      = d;
    out_ready    = rdy;
    if (stall_prev) begin
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_data", 16'(out_data), 16'(held));
    end
    if (out_valid === 1'b1) begin
      chk("out_da", 16'(out_da), 16'(exp_da));
    end else if (out_valid === 1'b0) begin
      chk("sop_without_valid", 16'(out_sop), 16'd0);
      chk("eop_without_valid", 16'(out_eop), 16'd0);
    end
    if (read_out === 1'b0) ro_low++;
    if (out_valid === 1'b1 && rdy) got_q.push_back({out_data, out_sop, out_eop});
    stall_prev = (out_valid === 1'b1) && !rdy;
    held       = out_data;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic stepx(input logic en, input logic [7:0] d);
    logic r;
    if (tog_mode) begin
      r   = tog;
      tog = ~tog;
    end else begin
      r = 1'b1;
    end
    step(en, d, r);
  endtask

  task automatic send_byte(input logic [7:0] d);
    if (tog_mode) stepx(1'b0, 8'h00);
    stepx(1'b1, d);
  endtask

  task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa,
                          input logic [7:0] len, input logic [7:0] base);
    send_byte(da);
    send_byte(sa);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) send_byte(base + 8'(i));
  endtask

  task automatic drain(input int n);
    repeat (n) stepx(1'b0, 8'h00);
  endtask

  task automatic exp_pkt(input logic [7:0] da, input logic [7:0] sa,
                         input logic [7:0] len, input logic [7:0] base);
    exp_da = da;
    exp_q.push_back({da, 1'b1, 1'b0});
    exp_q.push_back({sa, 1'b0, 1'b0});
    exp_q.push_back({len, 1'b0, 1'b0});
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({base + 8'(i), 1'b0, (i == int'(len) - 1)});
  endtask

  task automatic check_fwd(input string tag);
    int n;
    chk({tag, "_count"}, 16'(got_q.size()), 16'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, 16'(got_q[i]), 16'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    reset_n    = 1'b1;
    stall_prev = 1'b0;
    got_q.delete();
    chk("rst_read_out", 16'(read_out), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_sop", 16'(out_sop), 16'd0);
    chk("rst_out_eop", 16'(out_eop), 16'd0);
    chk("rst_out_data", 16'(out_data), 16'd0);
    chk("rst_out_da", 16'(out_da), 16'd0);
    chk("rst_drop_count", drop_count, 16'd0);
    chk("rst_overrun_count", overrun_count, 16'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    sw_enable_in = 1'b0;
    data_in      = 8'h00;
    out_ready    = 1'b1;
    @(negedge clock);
    do_reset();

    // Back-to-back packet, ready tied high.
    exp_pkt(8'h11, 8'h22, 8'd3, 8'hA0);
    ro_low = 0;
    send_pkt(8'h11, 8'h22, 8'd3, 8'hA0);
    drain(12);
    check_fwd("basic");
    chk("basic_read_out_low_cycles", 16'(ro_low), 16'd6);
    chk("basic_read_out_after", 16'(read_out), 16'd1);

    // Alternate-cycle enable with toggling ready.
    tog_mode = 1'b1;
    tog      = 1'b1;
    exp_pkt(8'h11, 8'h22, 8'd3, 8'hA0);
    send_pkt(8'h11, 8'h22, 8'd3, 8'hA0);
    drain(24);
    tog_mode = 1'b0;
    check_fwd("stalled");
    chk("stalled_drop_count", drop_count, 16'd0);

    // Zero-length packet dropped, then a one-byte packet forwarded.
    exp_pkt(8'h33, 8'h44, 8'd1, 8'h55);
    send_pkt(8'h5A, 8'h5B, 8'd0, 8'h00);
    send_pkt(8'h33, 8'h44, 8'd1, 8'h55);
    drain(8);
    chk("zero_len_drop_count", drop_count, 16'd1);
    check_fwd("zero_len");

    // Oversize packet discarded, then a valid two-byte packet.
    do_reset();
    exp_pkt(8'h66, 8'h67, 8'd2, 8'hB0);
    ro_low = 0;
    send_pkt(8'h77, 8'h78, 8'd100, 8'h00);
    chk("discard_read_out_low_cycles", 16'(ro_low), 16'd0);
    chk("discard_drop_count", drop_count, 16'd1);
    send_pkt(8'h66, 8'h67, 8'd2, 8'hB0);
    drain(10);
    check_fwd("after_discard");

    // Bytes offered during a stalled forward are counted as overruns.
    exp_pkt(8'h12, 8'h34, 8'd2, 8'hC0);
    send_pkt(8'h12, 8'h34, 8'd2, 8'hC0);
    repeat (5) step(1'b1, 8'hEE, 1'b0);
    chk("overrun_count", overrun_count, 16'd5);
    drain(10);
    chk("overrun_count_final", overrun_count, 16'd5);
    check_fwd("overrun");

    // Reset in mid-payload abandons the partial packet.
    send_byte(8'h90);
    send_byte(8'h91);
    send_byte(8'h04);
    send_byte(8'hD0);
    send_byte(8'hD1);
    do_reset();
    exp_pkt(8'h21, 8'h22, 8'd2, 8'hE0);
    send_pkt(8'h21, 8'h22, 8'd2, 8'hE0);
    drain(10);
    check_fwd("after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
